regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of writeback requesters (0=ALU, 1=MUL, 2=LSU); legal range 2..8.
REQ-002 Parameter XLEN, default 32: writeback data width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester writeback request.
REQ-006 req_rd  input  5*NUM_REQ  per-requester destination register, slice i = [5i+4:5i].
REQ-007 req_data  input  XLEN*NUM_REQ  per-requester result, slice i = [XLEN*i+XLEN-1:XLEN*i].
REQ-008 req_ready  output  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] && req_ready[i] at a rising edge.
REQ-009 reg_write  output  1  register-file write enable.
REQ-010 rd  output  5  register-file write address.
REQ-011 reg_write_data  output  XLEN  register-file write data.
REQ-012 rs1, rs2  input  5 each  decode-stage read addresses (same as sent to register file).
REQ-013 rf_rs1_data, rf_rs2_data  input  XLEN each  raw register-file read data.
REQ-014 rs1_data, rs2_data  output  XLEN each  bypassed read data to decode.
REQ-015 conflict_cnt  output  16  saturating count of cycles with two or more req_valid bits set.

Function
REQ-016 One output stage register (wb_valid, wb_rd, wb_data) SHALL hold the accepted request; it is reloaded every cycle (the register file never back-pressures).
REQ-017 req_ready SHALL be combinational, at most one bit set, and set only for a requester with req_valid high.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ, first valid requester wins.
REQ-019 last_grant SHALL update only on a cycle where a grant is issued; it holds otherwise.
REQ-020 A requester with req_valid high SHALL be granted within NUM_REQ cycles regardless of other traffic.
REQ-021 On an accept edge, wb_valid<=1, wb_rd<=req_rd[g], wb_data<=req_data[g]; with no request, wb_valid<=0 and wb_rd/wb_data hold.
REQ-022 Latency: request accepted at edge N SHALL drive reg_write during cycle N..N+1 and be written to the register file at edge N+1.
REQ-023 reg_write SHALL equal wb_valid && (wb_rd != 0); rd = wb_rd; reg_write_data = wb_data.
REQ-024 Requests with req_rd = 0 SHALL be accepted and arbitrated normally but produce no register write and no bypass.
REQ-025 rs1_data SHALL equal wb_data when wb_valid && wb_rd != 0 && wb_rd == rs1, else rf_rs1_data; rs2_data likewise with rs2.
REQ-026 rs1 = 0 or rs2 = 0 SHALL never bypass; output follows the register-file value (zero).
REQ-027 conflict_cnt SHALL increment by 1 on each edge where popcount(req_valid) >= 2 and saturate at 16'hFFFF.
REQ-028 Requester inputs SHALL not be required to hold after acceptance; a requester kept valid after acceptance is treated as a new request.

Reset
REQ-029 reset_n low SHALL immediately force wb_valid=0, wb_rd=0, wb_data=0, conflict_cnt=0, last_grant=NUM_REQ-1 (requester 0 highest priority on first arbitration).
REQ-030 During reset req_ready SHALL be all zeros and reg_write 0; an in-flight stage entry is discarded, not written.
REQ-031 First grant SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-032 Single request: req_valid=3'b010, req_rd[1]=5, data=32'hDEADBEEF -> req_ready=3'b010; next cycle reg_write=1, rd=5, reg_write_data=32'hDEADBEEF; x5 reads DEADBEEF after following edge.
REQ-033 All three valid continuously from reset for 6 cycles -> grant order 0,1,2,0,1,2; conflict_cnt=6.
REQ-034 Bypass: wb stage holds rd=7, data=32'h1234; rs1=7, rs2=7, rf data=0 -> rs1_data=rs2_data=32'h1234; rs1=8 -> rf_rs1_data passed.
REQ-035 rd=0: req_valid[2]=1, req_rd[2]=0, data=32'hFFFF_FFFF -> req_ready[2]=1, next cycle reg_write=0, rs1=0 yields rf value 0.
REQ-036 Reset mid-operation: request accepted, reset_n pulsed low before next edge -> reg_write=0, no register updated, conflict_cnt=0, next arbitration favours requester 0.
REQ-037 Saturation: force 65540 conflict cycles -> conflict_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the signals between the writeback arbiter and its neighbours:
//   - requester side : req_valid / req_rd / req_data in, req_ready out
//   - register file  : reg_write / rd / reg_write_data out,
//                      rf_rs1_data / rf_rs2_data raw read data in
//   - decode side    : rs1 / rs2 read addresses in, rs1_data / rs2_data out
//   - statistics     : conflict_cnt out
// master modport : the surrounding pipeline (requesters, register file, decode)
// slave modport  : the arbiter itself
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [5*NUM_REQ-1:0]    req_rd;
    logic [XLEN*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;

    logic                    reg_write;
    logic [4:0]              rd;
    logic [XLEN-1:0]         reg_write_data;

    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [XLEN-1:0]         rf_rs1_data;
    logic [XLEN-1:0]         rf_rs2_data;
    logic [XLEN-1:0]         rs1_data;
    logic [XLEN-1:0]         rs2_data;

    logic [15:0]             conflict_cnt;

    modport master (
        output req_valid, req_rd, req_data, rs1, rs2, rf_rs1_data, rf_rs2_data,
        input  req_ready, reg_write, rd, reg_write_data, rs1_data, rs2_data,
               conflict_cnt
    );

    modport slave (
        input  req_valid, req_rd, req_data, rs1, rs2, rf_rs1_data, rf_rs2_data,
        output req_ready, reg_write, rd, reg_write_data, rs1_data, rs2_data,
               conflict_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Round-robin arbiter that merges NUM_REQ writeback sources (0=ALU, 1=MUL,
// 2=LSU by default) into the single register-file write port.  The winner is
// captured in one writeback stage register which drives the register file
// write one cycle later and also feeds a bypass path back to decode.
//
// Ports:
//   clk      : clock, rising-edge active
//   reset_n  : asynchronous, active-low reset
//   bus      : regfile_wb_arbiter_if.slave (requesters, register file write,
//              decode read bypass, conflict counter)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int               IDX_W     = $clog2(NUM_REQ);
    // Resetting to the last requester makes requester 0 the first to win.
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [15:0]      conflict_cnt_q, conflict_cnt_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     cand_sum;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W:0]     vld_count;
    logic               wb_we;

    // Round-robin search starting just after the previous winner. The sum is
    // one bit wider than an index so the wrap can be done by one subtract.
    always_comb begin
        grant_oh    = '0;
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand_sum    = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = {1'b0, last_grant_q} + (IDX_W + 1)'(k);
            if (cand_sum >= NUM_REQ_W) begin
                cand_sum = cand_sum - NUM_REQ_W;
            end
            cand = cand_sum[IDX_W-1:0];
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found    = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        vld_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            vld_count = vld_count + (IDX_W + 1)'(bus.req_valid[i]);
        end
    end

    // Next-state for the writeback stage, arbitration pointer and counter.
    always_comb begin
        wb_valid_d = grant_found;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                wb_rd_d   = bus.req_rd[5*i +: 5];
                wb_data_d = bus.req_data[XLEN*i +: XLEN];
            end
        end

        last_grant_d = grant_found ? grant_idx : last_grant_q;

        conflict_cnt_d = conflict_cnt_q;
        if ((vld_count >= (IDX_W + 1)'(2)) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // ---- writeback stage register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= '0;
            last_grant_q   <= LAST_RST;
            conflict_cnt_q <= 16'd0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            last_grant_q   <= last_grant_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // The search above is purely combinational, so it is masked while reset
    // is held to keep requesters from seeing a grant that cannot be taken.
    assign bus.req_ready = reset_n ? grant_oh : '0;

    // x0 writes are swallowed here and are never forwarded.
    assign wb_we              = wb_valid_q && (wb_rd_q != 5'd0);
    assign bus.reg_write      = wb_we;
    assign bus.rd             = wb_rd_q;
    assign bus.reg_write_data = wb_data_q;

    assign bus.rs1_data = (wb_we && (wb_rd_q == bus.rs1)) ? wb_data_q : bus.rf_rs1_data;
    assign bus.rs2_data = (wb_we && (wb_rd_q == bus.rs2)) ? wb_data_q : bus.rf_rs2_data;

    assign bus.conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter: a table of per-cycle vectors followed
// by hand-written sequences for bypass, reset mid-flight, grant rotation and
// counter saturation. A small register file model sits on the write port.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    localparam int NR = 3;
    localparam int XL = 32;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(NR), .XLEN(XL)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(NR), .XLEN(XL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Register file model: x0 is hard-wired zero.
    logic [31:0] rf [32] = '{default: '0};
    always @(posedge clk) begin
        if (bus.reg_write && (bus.rd != 5'd0)) rf[bus.rd] <= bus.reg_write_data;
    end
    assign bus.rf_rs1_data = rf[bus.rs1];
    assign bus.rf_rs2_data = rf[bus.rs2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [14:0] rds,
                         input logic [95:0] ds, input logic [4:0] r1, input logic [4:0] r2);
        bus.req_valid = v;
        bus.req_rd    = rds;
        bus.req_data  = ds;
        bus.rs1       = r1;
        bus.rs2       = r2;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] rds;
        logic [95:0] ds;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  ready;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // Sequence starts right after reset: last_grant = 2, register file zero.
        vecs[0] = '{3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 5'd5, 5'd0,
                    3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 16'd0};
        vecs[1] = '{3'b000, 15'd0, 96'd0, 5'd5, 5'd5,
                    3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd0};
        vecs[2] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'h33333333, 32'h22222222, 32'h11111111}, 5'd3, 5'd2,
                    3'b100, 1'b1, 5'd3, 32'h33333333, 32'h33333333, 32'h0, 16'd1};
        vecs[3] = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'h33333333, 32'h22222222, 32'h11111111}, 5'd3, 5'd1,
                    3'b001, 1'b1, 5'd1, 32'h11111111, 32'h33333333, 32'h11111111, 16'd2};
        vecs[4] = '{3'b101, {5'd3, 5'd2, 5'd1}, {32'h33333333, 32'h22222222, 32'h11111111}, 5'd1, 5'd4,
                    3'b100, 1'b1, 5'd3, 32'h33333333, 32'h11111111, 32'h0, 16'd3};
        vecs[5] = '{3'b011, {5'd0, 5'd6, 5'd0}, {32'h0, 32'h66666666, 32'hFFFFFFFF}, 5'd0, 5'd3,
                    3'b001, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h33333333, 16'd4};
        vecs[6] = '{3'b011, {5'd0, 5'd6, 5'd0}, {32'h0, 32'h66666666, 32'hFFFFFFFF}, 5'd6, 5'd0,
                    3'b010, 1'b1, 5'd6, 32'h66666666, 32'h66666666, 32'h0, 16'd5};
        vecs[7] = '{3'b000, 15'd0, 96'd0, 5'd8, 5'd6,
                    3'b000, 1'b0, 5'd6, 32'h66666666, 32'h0, 32'h66666666, 16'd5};
        vecs[8] = '{3'b100, 15'd0, {32'hFFFFFFFF, 32'h0, 32'h0}, 5'd0, 5'd0,
                    3'b100, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 16'd5};
        vecs[9] = '{3'b011, {5'd0, 5'd10, 5'd9}, {32'h0, 32'hAAAAAAAA, 32'h99999999}, 5'd9, 5'd10,
                    3'b001, 1'b1, 5'd9, 32'h99999999, 32'h99999999, 32'h0, 16'd6};

        // Reset state, with every requester asserting.
        drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 5'd0, 5'd0);
        edge_step();
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_we", 32'(bus.reg_write), 32'h0);
        chk("rst_rd", 32'(bus.rd), 32'h0);
        chk("rst_wdata", bus.reg_write_data, 32'h0);
        chk("rst_cnt", 32'(bus.conflict_cnt), 32'h0);
        edge_step();
        reset_n = 1'b1;

        // Table vectors.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].rds, vecs[i].ds, vecs[i].rs1, vecs[i].rs2);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].ready));
            edge_step();
            chk($sformatf("v%0d_we", i), 32'(bus.reg_write), 32'(vecs[i].we));
            chk($sformatf("v%0d_rd", i), 32'(bus.rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_wdata", i), bus.reg_write_data, vecs[i].wdata);
            chk($sformatf("v%0d_rs1d", i), bus.rs1_data, vecs[i].rs1d);
            chk($sformatf("v%0d_rs2d", i), bus.rs2_data, vecs[i].rs2d);
            chk($sformatf("v%0d_cnt", i), 32'(bus.conflict_cnt), 32'(vecs[i].cnt));
        end

        // Bypass: x8 gets written, x7 sits in the writeback stage.
        drive(3'b010, {5'd0, 5'd8, 5'd0}, {32'h0, 32'h88888888, 32'h0}, 5'd0, 5'd0);
        edge_step();
        drive(3'b100, {5'd7, 5'd0, 5'd0}, {32'h00001234, 32'h0, 32'h0}, 5'd0, 5'd0);
        edge_step();
        drive(3'b000, 15'd0, 96'd0, 5'd7, 5'd7);
        #1;
        chk("byp_we", 32'(bus.reg_write), 32'h1);
        chk("byp_rs1", bus.rs1_data, 32'h00001234);
        chk("byp_rs2", bus.rs2_data, 32'h00001234);
        bus.rs1 = 5'd8;
        #1;
        chk("byp_rs1_rf", bus.rs1_data, 32'h88888888);

        // Reset while x12 is in the writeback stage.
        edge_step();
        drive(3'b110, {5'd15, 5'd14, 5'd0}, {32'hF0F0F0F0, 32'hE0E0E0E0, 32'h0}, 5'd0, 5'd0);
        edge_step();
        drive(3'b001, {5'd0, 5'd0, 5'd12}, {32'h0, 32'h0, 32'hC0C0C0C0}, 5'd0, 5'd0);
        edge_step();
        chk("mid_pre_we", 32'(bus.reg_write), 32'h1);
        reset_n = 1'b0;
        drive(3'b111, {5'd0, 5'd0, 5'd12}, {32'h0, 32'h0, 32'hC0C0C0C0}, 5'd12, 5'd0);
        #1;
        chk("mid_we", 32'(bus.reg_write), 32'h0);
        chk("mid_rd", 32'(bus.rd), 32'h0);
        chk("mid_cnt", 32'(bus.conflict_cnt), 32'h0);
        chk("mid_ready", 32'(bus.req_ready), 32'h0);
        edge_step();
        chk("mid_x12", bus.rs1_data, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("mid_first_grant", 32'(bus.req_ready), 32'h1);

        // Grant rotation from a fresh reset with all requesters held valid.
        edge_step();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 5'd0, 5'd0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr%0d_ready", i), 32'(bus.req_ready), 32'(3'b001 << (i % 3)));
            edge_step();
        end
        chk("rr_cnt", 32'(bus.conflict_cnt), 32'd6);

        // Counter saturation: 65540 conflict cycles in total.
        for (int i = 0; i < 65528; i++) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(bus.conflict_cnt), 32'h0000FFFE);
        edge_step();
        chk("sat_ffff", 32'(bus.conflict_cnt), 32'h0000FFFF);
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        chk("sat_hold", 32'(bus.conflict_cnt), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
